// File: rtl/quad_rpm_meter.sv
// Quadrature encoder front end: synchronises A/B, decodes x4 steps into a
// wrapping signed position and a gated per-window count, and scales each
// closed window into a saturated signed RPM value.
module quad_rpm_meter #(
  parameter int unsigned GATE_CYCLES = 1_000_000,
  parameter int unsigned RPM_MUL     = 375,
  parameter int unsigned RPM_SHIFT   = 6
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               enc_a_i,
  input  logic               enc_b_i,
  input  logic               enable_i,
  input  logic               dir_invert_i,
  output logic signed [15:0] rpm_o,
  output logic               rpm_valid_o,
  output logic               rpm_stb_o,
  output logic signed [31:0] position_o,
  output logic               enc_err_o
);

  localparam int unsigned TW = $clog2(GATE_CYCLES);
  localparam logic [TW-1:0] TimerLast = TW'(GATE_CYCLES - 1);
  localparam logic [TW-1:0] TimerOne  = TW'(1);

  logic        a_s1_q, a_s2_q, b_s1_q, b_s2_q;
  logic [1:0]  prev_ab_q, cur_ab, diff_ab;
  // Decoding stays off until the synchronisers hold real pin values, so the
  // initial A/B state never looks like a step or an illegal jump.
  logic [1:0]  arm_q;
  logic        fwd, err_ev;
  logic signed [1:0]  step;

  logic signed [31:0] position_q;
  logic               enc_err_q;

  logic [TW-1:0]      timer_q;
  logic               terminal;
  logic signed [15:0] win_cnt_q, win_sat;
  logic signed [16:0] win_sum;
  logic signed [31:0] prod_d, prod_q, shifted;
  logic               s1_vld_q;
  logic signed [15:0] rpm_d, rpm_q;
  logic               rpm_valid_q, rpm_stb_q;

  // Two-flop synchronisers, previous-state register and decode arming
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      a_s1_q    <= 1'b0;
      a_s2_q    <= 1'b0;
      b_s1_q    <= 1'b0;
      b_s2_q    <= 1'b0;
      prev_ab_q <= 2'b00;
      arm_q     <= 2'd0;
    end else begin
      a_s1_q    <= enc_a_i;
      a_s2_q    <= a_s1_q;
      b_s1_q    <= enc_b_i;
      b_s2_q    <= b_s1_q;
      prev_ab_q <= cur_ab;
      if (arm_q != 2'd3) arm_q <= arm_q + 2'd1;
    end
  end

  // x4 decode: forward is 00->10->11->01->00, a double-bit change is illegal
  always_comb begin
    cur_ab  = {a_s2_q, b_s2_q};
    diff_ab = prev_ab_q ^ cur_ab;
    fwd     = cur_ab[1] ^ prev_ab_q[0];
    step    = 2'sd0;
    err_ev  = 1'b0;
    if (arm_q == 2'd3) begin
      case (diff_ab)
        2'b00:   step = 2'sd0;
        2'b11:   err_ev = 1'b1;
        default: step = (fwd ^ dir_invert_i) ? 2'sd1 : -2'sd1;
      endcase
    end
  end

  // Position integrates every step regardless of enable; error flag is sticky
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      position_q <= '0;
      enc_err_q  <= 1'b0;
    end else begin
      position_q <= position_q + {{30{step[1]}}, step};
      if (err_ev) enc_err_q <= 1'b1;
    end
  end

  // Saturating window sum and the two-stage scale datapath
  always_comb begin
    terminal = (timer_q == TimerLast);
    win_sum  = {win_cnt_q[15], win_cnt_q} + {{15{step[1]}}, step};
    if (win_sum > 17'sd32767)        win_sat = 16'sh7fff;
    else if (win_sum < -17'sd32768)  win_sat = 16'sh8000;
    else                             win_sat = win_sum[15:0];
    prod_d  = $signed({{16{win_sat[15]}}, win_sat}) * $signed(32'(RPM_MUL));
    shifted = prod_q >>> RPM_SHIFT;
    if (shifted > 32'sd32767)        rpm_d = 16'sd32767;
    else if (shifted < -32'sd32767)  rpm_d = -16'sd32767;
    else                             rpm_d = shifted[15:0];
  end

  // Gate timer, window counter, S1/S2 pipeline and registered outputs
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      timer_q     <= '0;
      win_cnt_q   <= '0;
      s1_vld_q    <= 1'b0;
      prod_q      <= '0;
      rpm_q       <= '0;
      rpm_valid_q <= 1'b0;
      rpm_stb_q   <= 1'b0;
    end else if (!enable_i) begin
      timer_q     <= '0;
      win_cnt_q   <= '0;
      s1_vld_q    <= 1'b0;
      prod_q      <= '0;
      rpm_q       <= '0;
      rpm_valid_q <= 1'b0;
      rpm_stb_q   <= 1'b0;
    end else begin
      s1_vld_q  <= terminal;
      if (terminal) prod_q <= prod_d;
      rpm_stb_q <= s1_vld_q;
      if (s1_vld_q) begin
        rpm_q       <= rpm_d;
        rpm_valid_q <= 1'b1;
      end
      // The terminal-cycle step belongs to the closing window only
      if (terminal) begin
        timer_q   <= '0;
        win_cnt_q <= '0;
      end else begin
        timer_q   <= timer_q + TimerOne;
        win_cnt_q <= win_sat;
      end
    end
  end

  assign rpm_o       = rpm_q;
  assign rpm_valid_o = rpm_valid_q;
  assign rpm_stb_o   = rpm_stb_q;
  assign position_o  = position_q;
  assign enc_err_o   = enc_err_q;

endmodule

// File: tb/tb_quad_rpm_meter.sv
// Directed bench for quad_rpm_meter: one instance with a 1000-cycle gate for
// timing/boundary/enable checks, one with a 30000-cycle gate for saturation.
module tb_quad_rpm_meter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [1:0] ab1 = 2'b00, ab2 = 2'b00;
  logic       en1 = 1'b0, en2 = 1'b0, inv1 = 1'b0, inv2 = 1'b0;

  logic signed [15:0] rpm1, rpm2;
  logic               vld1, vld2, stb1, stb2, err1, err2;
  logic signed [31:0] pos1, pos2;

  quad_rpm_meter #(.GATE_CYCLES(1000), .RPM_MUL(375), .RPM_SHIFT(6)) u_dut (
    .clk_i(clk), .rst_i(rst), .enc_a_i(ab1[1]), .enc_b_i(ab1[0]),
    .enable_i(en1), .dir_invert_i(inv1), .rpm_o(rpm1), .rpm_valid_o(vld1),
    .rpm_stb_o(stb1), .position_o(pos1), .enc_err_o(err1)
  );

  quad_rpm_meter #(.GATE_CYCLES(30000), .RPM_MUL(375), .RPM_SHIFT(6)) u_dut_sat (
    .clk_i(clk), .rst_i(rst), .enc_a_i(ab2[1]), .enc_b_i(ab2[0]),
    .enable_i(en2), .dir_invert_i(inv2), .rpm_o(rpm2), .rpm_valid_o(vld2),
    .rpm_stb_o(stb2), .position_o(pos2), .enc_err_o(err2)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int idx1    = 0;
  int idx2    = 0;
  logic [1:0] seq [4];

  task automatic chk(input string tag, input logic signed [31:0] got,
                     input logic signed [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Advance to negedge number k counted from the last cyc reset
  task automatic wait_to(input int k);
    while (cyc < k) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  // Move the first encoder by dir positions along the forward sequence
  task automatic step1(input int dir);
    idx1 = (idx1 + dir + 4) % 4;
    ab1  = seq[idx1];
  endtask

  task automatic step2(input int dir);
    idx2 = (idx2 + dir + 4) % 4;
    ab2  = seq[idx2];
  endtask

  initial begin
    seq[0] = 2'b00; seq[1] = 2'b10; seq[2] = 2'b11; seq[3] = 2'b01;

    // Reset held while pins toggle
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      ab1 = ab1 + 2'b01;
    end
    chk("rst_rpm", rpm1, 0);
    chk("rst_valid", vld1, 0);
    chk("rst_stb", stb1, 0);
    chk("rst_pos", pos1, 0);
    chk("rst_err", err1, 0);
    ab1  = 2'b11;
    idx1 = 2;
    @(negedge clk);
    rst = 1'b0;
    repeat (8) @(negedge clk);
    chk("release_pos", pos1, 0);
    chk("release_err", err1, 0);

    // Window 1: 100 forward steps
    en1 = 1'b1;
    cyc = 0;
    for (int i = 0; i < 100; i++) begin
      wait_to(1 + 2 * i);
      step1(1);
    end
    wait_to(1000);
    chk("w1_stb_early", stb1, 0);
    chk("w1_valid_early", vld1, 0);
    wait_to(1001);
    chk("w1_stb", stb1, 1);
    chk("w1_rpm", rpm1, 585);
    chk("w1_valid", vld1, 1);
    chk("w1_pos", pos1, 100);
    wait_to(1002);
    chk("w1_stb_pulse", stb1, 0);

    // Window 2: 10 steps plus one decoded on the terminal cycle
    for (int i = 0; i < 10; i++) begin
      wait_to(1100 + 2 * i);
      step1(1);
    end
    wait_to(1997);
    step1(1);
    // Window 3: one step just after the terminal cycle
    wait_to(1999);
    step1(1);
    wait_to(2001);
    chk("w2_stb", stb1, 1);
    chk("w2_rpm", rpm1, 64);
    wait_to(3001);
    chk("w3_stb", stb1, 1);
    chk("w3_rpm", rpm1, 5);
    chk("w3_pos", pos1, 112);

    // Window 4: 20 steps, then enable drops one cycle after terminal
    for (int i = 0; i < 20; i++) begin
      wait_to(3100 + 2 * i);
      step1(1);
    end
    wait_to(4000);
    en1 = 1'b0;
    wait_to(4001);
    chk("drop_stb", stb1, 0);
    chk("drop_rpm", rpm1, 0);
    chk("drop_valid", vld1, 0);
    wait_to(4002);
    chk("drop_stb_late", stb1, 0);
    step1(1);
    wait_to(4010);
    chk("disabled_pos", pos1, 133);
    chk("disabled_stb", stb1, 0);

    // Re-enable with inverted direction: 100 forward steps count down
    inv1 = 1'b1;
    en1  = 1'b1;
    cyc  = 0;
    for (int i = 0; i < 100; i++) begin
      wait_to(1 + 2 * i);
      step1(1);
    end
    wait_to(1000);
    chk("inv_stb_early", stb1, 0);
    wait_to(1001);
    chk("inv_stb", stb1, 1);
    chk("inv_rpm", rpm1, -586);
    chk("inv_pos", pos1, 33);
    chk("inv_err", err1, 0);

    // Illegal double-bit jump
    wait_to(1010);
    step1(2);
    wait_to(1020);
    chk("illegal_err", err1, 1);
    chk("illegal_pos", pos1, 33);

    // Saturation on the long-gate instance
    en2 = 1'b1;
    cyc = 0;
    for (int i = 0; i < 6000; i++) begin
      wait_to(1 + 2 * i);
      step2(1);
    end
    wait_to(30000);
    chk("sat_stb_early", stb2, 0);
    wait_to(30001);
    chk("sat_stb", stb2, 1);
    chk("sat_rpm", rpm2, 32767);
    chk("sat_valid", vld2, 1);
    chk("sat_pos", pos2, 6000);
    chk("sat_err", err2, 0);

    // Mid-window reset returns everything to zero
    wait_to(30100);
    rst = 1'b1;
    wait_to(30101);
    chk("midrst_rpm", rpm2, 0);
    chk("midrst_valid", vld2, 0);
    chk("midrst_pos", pos2, 0);
    chk("midrst_err1", err1, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/quad_rpm_meter.md
# quad_rpm_meter

Quadrature encoder front end for the speed loop. Synchronises raw encoder A/B, decodes x4 steps into a signed position and a per-window step count, and converts each gate window into signed RPM. The `rpm` and `rpm_valid` outputs are the feedback source for the PID controller, so the RPM scaling here must match the PID's feedback convention.

## Interface
- `GATE_CYCLES`, default 1_000_000: gate window length in clk cycles (10 ms at 100 MHz); range ≥ 4.
- `RPM_MUL`, default 375: RPM scale numerator.
- `RPM_SHIFT`, default 6: RPM scale right shift. The defaults give 6000/1024 ≈ 375/64 for a 1024 count/rev (x4) encoder at a 10 ms gate.
- `clk` in 1: system clock.
- `rst` in 1: asynchronous, active-high reset.
- `enc_a` in 1: encoder channel A, asynchronous.
- `enc_b` in 1: encoder channel B, asynchronous.
- `enable` in 1: measurement enable.
- `dir_invert` in 1: negate step direction. Static; change only while `enable` = 0.
- `rpm` out 16 signed: latest speed, saturated to ±32767.
- `rpm_valid` out 1: level. High once the first full window completes while enabled.
- `rpm_stb` out 1: one-cycle pulse on each `rpm` update.
- `position` out 32 signed: accumulated steps, wraps modulo 2^32.
- `enc_err` out 1: sticky flag for an illegal (double-bit) transition.

## Operation
- **Synchronizer.** A and B each pass through 2 flip-flops. A third register holds the previous synchronized state `prev_ab`.
- **Decode.** Compare `prev_ab` with `cur_ab = {A,B}` every cycle.
  - Forward sequence 00→10→11→01→00: +1.
  - Reverse sequence 00→01→11→10→00: −1.
  - No change: 0.
  - Both bits changed: 0, and set `enc_err`.
  - `dir_invert` negates the step.
- **Position.** `position += step` every cycle regardless of `enable`. Wraps on overflow.
- **Window counter.** `win_cnt` is 16-bit signed and saturates at +32767/−32768.
  - It accumulates steps only while `enable` = 1.
- **Gate timer.** Counts 0..`GATE_CYCLES`−1 while `enable` = 1.
  - On the terminal cycle, the closing window captures `win_cnt` + that cycle's step (saturated).
  - `win_cnt` restarts at 0. That cycle's step belongs to the closed window only.
- **Scale pipeline.**
  - S1: `prod = captured × RPM_MUL`, 32-bit signed.
  - S2: `q = prod >>> RPM_SHIFT` (arithmetic, floor), saturated to [−32767, +32767], then registered to `rpm`.
  - Assert `rpm_stb` with the `rpm` update; set `rpm_valid`.
- **`enable` low.**
  - Timer and `win_cnt` held at 0.
  - Pipeline contents discarded (no stb).
  - `rpm` ← 0, `rpm_valid` ← 0.
  - On re-enable, the first update comes after a full new window.
- **Clearing `enc_err`.** Cleared only by `rst`.

## Timing
- **Reset values:** `rpm` = 0, `rpm_valid` = 0, `rpm_stb` = 0, `position` = 0, `enc_err` = 0.
  - Timer, `win_cnt`, pipeline, synchronizers = 0.
  - `prev_ab` loads `cur_ab` on the first post-reset cycle, so no spurious step.
- **Input-to-count latency:** a pin change affects `position` 3 clk edges later (2 sync + 1 decode/accumulate).
- **Minimum encoder state dwell:** 2 clk cycles. Faster input may alias into `enc_err`.
- **Window period:** first update after `enable` rises is `GATE_CYCLES` cycles later, then every `GATE_CYCLES` cycles.
- **Output latency:** `rpm`/`rpm_stb` update 2 cycles after the terminal cycle (S1, S2).
- **`enable` falling:** if it falls while S1/S2 hold data, the data is dropped, and `rpm`/`rpm_valid` clear on the next edge.
- **`rst` mid-window or mid-pipeline:** immediate return to the reset values above.
- **Simultaneous events:** a step in the terminal cycle is included in the closing window. A step while `enable` = 0 updates `position` only.

## Test plan
- **Reset/idle:** assert `rst` with A/B toggling → all outputs 0. Release → no `position` step from the initial A/B state.
- **Forward speed** (`GATE_CYCLES`=1000): 100 forward steps inside one window → `rpm_stb` 2 cycles after terminal, `rpm` = 585 (37500>>>6), `rpm_valid` = 1, `position` = 100.
- **Reverse with invert:** 100 forward steps with `dir_invert`=1 → `rpm` = −586 (floor), `position` = −100.
- **Saturation:** 6000 steps in one window (`GATE_CYCLES`=30000) → `rpm` = 32767. An illegal 00→11 jump → `enc_err` = 1, no count change.
- **Boundary step:** a step decoded exactly on the terminal cycle → counted in the closing window. The next window starts at 0.
- **Enable drop mid-pipeline:** deassert `enable` 1 cycle after terminal → no `rpm_stb`, `rpm` = 0, `rpm_valid` = 0. Re-enable → first `rpm_stb` after a full window + 2 cycles.
